// File: rtl/jtgng_video_pkg.sv
// rtl/jtgng_video_pkg.sv - shared video timing constants, count widths and decode helpers
package jtgng_video_pkg;

  // Counter widths shared by the timing block and the scan doubler
  localparam int H_W = 9;
  localparam int V_W = 9;

  // Default horizontal timing, in 6 MHz pixels
  localparam int HTOTAL_DEF   = 384;
  localparam int HB_START_DEF = 256;
  localparam int HS_START_DEF = 296;
  localparam int HS_END_DEF   = 328;

  // Default vertical timing, in lines
  localparam int VTOTAL_DEF   = 262;
  localparam int VB_END_DEF   = 16;
  localparam int VB_START_DEF = 240;
  localparam int VS_START_DEF = 248;
  localparam int VS_END_DEF   = 252;

  // Blanking and sync flags; blanking is high while active, syncs are low in the pulse
  typedef struct packed {
    logic lhbl;
    logic lvbl;
    logic hs;
    logic vs;
  } vid_ctl_t;

  // Reset value: everything blanked, both syncs idle high
  localparam vid_ctl_t CTL_RST = '{lhbl: 1'b0, lvbl: 1'b0, hs: 1'b1, vs: 1'b1};

  // True when lo <= cnt < hi
  function automatic logic in_range(input int cnt, input int lo, input int hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/jtgng_vidcnt.sv
// rtl/jtgng_vidcnt.sv - wrap counter with enable, next-value look-ahead and end-of-count flag
module jtgng_vidcnt #(
  parameter int W     = 9,
  parameter int TOTAL = 384
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] next_o,
  output logic         end_o
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign end_o  = (cnt_q == LAST);
  assign cnt_o  = cnt_q;
  // The look-ahead lets the parent register decodes that line up with the count
  assign next_o = cnt_d;

  // Next count: step when enabled, wrapping to zero after the last value
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = end_o ? '0 : cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/jtgng_vidtiming.sv
// rtl/jtgng_vidtiming.sv - H/V scan counters, blanking, sync, colour blanking and frame pulse
module jtgng_vidtiming
  import jtgng_video_pkg::*;
#(
  parameter int HTOTAL   = HTOTAL_DEF,
  parameter int HB_START = HB_START_DEF,
  parameter int HS_START = HS_START_DEF,
  parameter int HS_END   = HS_END_DEF,
  parameter int VTOTAL   = VTOTAL_DEF,
  parameter int VB_END   = VB_END_DEF,
  parameter int VB_START = VB_START_DEF,
  parameter int VS_START = VS_START_DEF,
  parameter int VS_END   = VS_END_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen6,
  input  logic [3:0]     red_in,
  input  logic [3:0]     green_in,
  input  logic [3:0]     blue_in,
  output logic [H_W-1:0] H,
  output logic [V_W-1:0] V,
  output logic           LHBL,
  output logic           LVBL,
  output logic           HS,
  output logic           VS,
  output logic [3:0]     red,
  output logic [3:0]     green,
  output logic [3:0]     blue,
  output logic           frame_start
);

  logic           h_end;
  logic           v_end;
  logic [H_W-1:0] h_next;
  logic [V_W-1:0] v_next;

  vid_ctl_t       ctl_q;
  vid_ctl_t       ctl_d;
  logic [3:0]     red_q;
  logic [3:0]     red_d;
  logic [3:0]     green_q;
  logic [3:0]     green_d;
  logic [3:0]     blue_q;
  logic [3:0]     blue_d;
  logic           fs_q;
  logic           fs_d;
  logic           active;

  jtgng_vidcnt #(
    .W     (H_W),
    .TOTAL (HTOTAL)
  ) u_hcnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (cen6),
    .cnt_o  (H),
    .next_o (h_next),
    .end_o  (h_end)
  );

  // V steps only on the pixel where H wraps
  jtgng_vidcnt #(
    .W     (V_W),
    .TOTAL (VTOTAL)
  ) u_vcnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (cen6 & h_end),
    .cnt_o  (V),
    .next_o (v_next),
    .end_o  (v_end)
  );

  // Decode the next H/V so registered flags and colour stay aligned with the counters
  always_comb begin
    ctl_d   = ctl_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    fs_d    = 1'b0;
    active  = ctl_q.lhbl & ctl_q.lvbl;
    if (cen6) begin
      ctl_d.lhbl = in_range(int'(h_next), 0, HB_START);
      ctl_d.lvbl = in_range(int'(v_next), VB_END, VB_START);
      ctl_d.hs   = ~in_range(int'(h_next), HS_START, HS_END);
      // v_next only moves on an H wrap, so VS can only toggle there
      ctl_d.vs   = ~in_range(int'(v_next), VS_START, VS_END);
      active     = ctl_d.lhbl & ctl_d.lvbl;
      red_d      = active ? red_in   : 4'd0;
      green_d    = active ? green_in : 4'd0;
      blue_d     = active ? blue_in  : 4'd0;
      fs_d       = h_end & v_end;
    end
  end

  // Output registers; frame_start clears on the very next clk
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q   <= CTL_RST;
      red_q   <= 4'd0;
      green_q <= 4'd0;
      blue_q  <= 4'd0;
      fs_q    <= 1'b0;
    end else begin
      ctl_q   <= ctl_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      fs_q    <= fs_d;
    end
  end

  assign LHBL        = ctl_q.lhbl;
  assign LVBL        = ctl_q.lvbl;
  assign HS          = ctl_q.hs;
  assign VS          = ctl_q.vs;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign frame_start = fs_q;

endmodule
